// File: rtl/crypto_stream_hash.sv
// Streaming keyed hash: ROUNDS rotate-xor rounds per input word, digest emitted after in_last.
// Optional build macro CRYPTO_LEN_FINAL_EN folds the message word count into the digest.
module crypto_stream_hash #(
    parameter int                DATA_W   = 8,
    parameter int                KEY_W    = 10,
    parameter int                HASH_W   = 32,
    parameter int                ROUNDS   = 4,
    parameter int                ROT      = 5,
    parameter logic [HASH_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEY_W-1:0]  in_key,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HASH_W-1:0] out_hash,
    output logic              busy,
    output logic [15:0]       word_cnt
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] data_q;
    logic [KEY_W-1:0]  key_q;
    logic              last_q;
    logic [RW-1:0]     r;
    logic [HASH_W-1:0] h, h_next, digest;
    logic              last_round;

    assign last_round = (r == RW'(ROUNDS - 1));
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    // One mixing round: rotate the state, then fold in word + key + round index.
    assign h_next = ((h << ROT) | (h >> (HASH_W - ROT)))
                  ^ (HASH_W'(data_q) + HASH_W'(key_q) + HASH_W'(r));

`ifdef CRYPTO_LEN_FINAL_EN
    assign digest = h_next ^ HASH_W'(word_cnt);
`else
    assign digest = h_next;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = ROUND;
            ROUND:   if (last_round) state_next = last_q ? DONE : IDLE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: the word/key holding registers are always written before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            data_q <= in_data;
            key_q  <= in_key;
            last_q <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h        <= INIT_VAL;
            r        <= '0;
            word_cnt <= '0;
            out_hash <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r <= '0;
                        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                    end
                end
                ROUND: begin
                    h <= h_next;
                    r <= r + RW'(1);
                    if (last_round && last_q) out_hash <= digest;
                end
                DONE: begin
                    if (out_ready) begin
                        h        <= INIT_VAL;
                        word_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_stream_hash.sv
// Self-checking bench for crypto_stream_hash: directed vectors plus random multi-word messages
// compared against a word-by-word arithmetic model of the hash.
module tb_crypto_stream_hash;

    localparam int ROUNDS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [9:0]  in_key;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_hash;
    logic        busy;
    logic [15:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    crypto_stream_hash dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Digest rule from the message: every word runs ROUNDS rotate-by-5 xor rounds.
    function automatic logic [31:0] ref_hash(input logic [7:0] d[16], input logic [9:0] k[16],
                                             input int len);
        logic [31:0] hv = 32'h0;
        for (int w = 0; w < len; w++)
            for (int rr = 0; rr < ROUNDS; rr++)
                hv = {hv[26:0], hv[31:27]} ^ (32'(d[w]) + 32'(k[w]) + 32'(rr));
`ifdef CRYPTO_LEN_FINAL_EN
        hv = hv ^ 32'(len);
`endif
        return hv;
    endfunction

    task automatic send_word(input logic [7:0] d, input logic [9:0] k, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  d_arr[16];
        logic [9:0]  k_arr[16];
        logic [31:0] exp_h;
        logic [31:0] held;
        int          cyc;
        int          len;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_word_cnt",  32'(word_cnt),  32'd0);
        check("rst_out_hash",  out_hash,       32'd0);

        // Single zero word: latency and digest.
        d_arr[0] = 8'h00; k_arr[0] = 10'h000;
        send_word(8'h00, 10'h000, 1'b1);
        check("busy_in_round", 32'(busy), 32'd1);
        wait_out(cyc);
        check("latency_rounds", 32'(cyc), 32'(ROUNDS));
        exp_h = ref_hash(d_arr, k_arr, 1);
`ifndef CRYPTO_LEN_FINAL_EN
        check("model_zero_const", exp_h, 32'h0000_0443);
`endif
        check("hash_zero", out_hash, exp_h);
        check("cnt_in_done", 32'(word_cnt), 32'd1);
        handshake();
        check("done_released", 32'(out_valid), 32'd0);
        check("cnt_cleared", 32'(word_cnt), 32'd0);
        check("hash_held_after", out_hash, exp_h);

        // All-ones word and key.
        d_arr[0] = 8'hFF; k_arr[0] = 10'h3FF;
        send_word(8'hFF, 10'h3FF, 1'b1);
        wait_out(cyc);
        exp_h = ref_hash(d_arr, k_arr, 1);
        check("hash_ones", out_hash, exp_h);
        handshake();

        // Back-pressure: digest held for 10 cycles, then next message from INIT_VAL.
        d_arr[0] = 8'h00; k_arr[0] = 10'h000;
        exp_h = ref_hash(d_arr, k_arr, 1);
        send_word(8'h00, 10'h000, 1'b1);
        wait_out(cyc);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hash",  out_hash,       exp_h);
            check("stall_ready", 32'(in_ready),  32'd0);
        end
        handshake();
        send_word(8'h00, 10'h000, 1'b1);
        wait_out(cyc);
        check("hash_after_stall", out_hash, exp_h);
        handshake();

        // in_valid held through ROUND consumes one word only.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_key   = 10'h123;
        in_last  = 1'b0;
        for (int i = 0; i <= ROUNDS; i++) tick();
        in_valid = 1'b0;
        check("hold_word_cnt", 32'(word_cnt), 32'd1);
        check("hold_idle",     32'(in_ready), 32'd1);

        // Reset mid-ROUND aborts; next message starts clean.
        send_word(8'h33, 10'h2AA, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready",  32'(in_ready),  32'd1);
        check("abort_busy",   32'(busy),      32'd0);
        check("abort_cnt",    32'(word_cnt),  32'd0);
        for (int i = 0; i < ROUNDS + 2; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send_word(8'h00, 10'h000, 1'b1);
        wait_out(cyc);
        check("hash_after_abort", out_hash, exp_h);
        handshake();

        // Random multi-word messages with per-word keys and stray out_ready.
        for (int m = 0; m < 25; m++) begin
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                d_arr[w] = 8'($urandom);
                k_arr[w] = 10'($urandom);
                out_ready = (w < len - 1) ? 1'($urandom) : 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                send_word(d_arr[w], k_arr[w], w == len - 1);
            end
            out_ready = 1'b0;
            wait_out(cyc);
            exp_h = ref_hash(d_arr, k_arr, len);
            check("rand_hash", out_hash, exp_h);
            check("rand_cnt",  32'(word_cnt), 32'(len));
            repeat ($urandom_range(0, 3)) tick();
            handshake();
            check("rand_release", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
